fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'd0, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter HALT_INSTR, default 16'h0000, meaning the encoding treated as end-of-program (the instruction memory returns it for unmapped addresses).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc_out  output  16  current fetch address, driven to the instruction memory.
REQ-006 SHALL have port instr_in  input  16  instruction returned combinationally by the instruction memory for pc_out.
REQ-007 SHALL have port stall  input  1  hazard-unit request to hold the PC and the IF/ID contents.
REQ-008 SHALL have port branch_taken  input  1  EX stage resolved a taken BZ this cycle.
REQ-009 SHALL have port branch_target  input  16  redirect address (pc+1+sign-extended imm6), valid with branch_taken.
REQ-010 SHALL have port if_id_instr  output  16  registered instruction passed to decode.
REQ-011 SHALL have port if_id_pc1  output  16  registered pc+1 of that instruction.
REQ-012 SHALL have port if_id_valid  output  1  the IF/ID contents are a real instruction, not a bubble.
REQ-013 SHALL have port halted  output  1  high while in the HALTED state.
REQ-014 SHALL have port fetch_count  output  16  number of instructions delivered with valid=1.

Function
REQ-015 SHALL implement two states: RUN and HALTED.
REQ-016 pc_out SHALL equal the PC register, with no combinational path from any input.
REQ-017 Priority each cycle SHALL be branch_taken > stall > halt detect > normal fetch.
REQ-018 branch_taken, any state: PC<=branch_target; if_id_instr<=0; if_id_valid<=0; state<=RUN; stall ignored that cycle.
REQ-019 RUN, stall=1, no branch: PC, if_id_instr, if_id_pc1, if_id_valid and fetch_count SHALL all hold.
REQ-020 RUN, instr_in==HALT_INSTR, no stall, no branch: valid<=0; PC holds; state<=HALTED.
REQ-021 RUN, normal fetch: if_id_instr<=instr_in; if_id_pc1<=PC+1; valid<=1; PC<=PC+1; fetch_count+1.
REQ-022 Normal fetch SHALL have 1-cycle latency: the instruction at address A appears on if_id_* on the edge after pc_out==A.
REQ-023 HALTED, no branch: PC frozen; valid<=0; stall has no effect.
REQ-024 PC+1 and fetch_count SHALL wrap modulo 2^16 (16'hFFFF+1 = 0), with no flag.
REQ-025 if_id_pc1 SHALL hold its previous value whenever a bubble is inserted.

Reset
REQ-026 rst low SHALL immediately force PC=RESET_PC, if_id_instr=0, if_id_pc1=0, if_id_valid=0, fetch_count=0, state=RUN, halted=0.
REQ-027 Reset asserted mid-stall or mid-branch SHALL win over all other inputs.
REQ-028 The first fetch after deassertion SHALL occur at the first rising edge with rst high.

Structure
REQ-029 The shared package cpu_pkg SHALL hold:
- opcode constants: ADD=0001, SUB=0010, OR=0100, XOR=0101, SL=0110, LOAD=1010, STORE=1011, BZ=1100;
- the HALT_INSTR default;
- the fetch state encoding;
- field widths: opcode 4, register 3, imm6 6.
REQ-030 No sub-module; the PC register, the IF/ID register, the FSM and the counter live in fetch_stage. It is instantiated beside instruction_mem, connected pc_out->pc_out and instr_out->instr_in.

Verification
REQ-031 Reset release with instr_in=16'hB683 at PC 0 -> next edge: if_id_instr=B683, if_id_pc1=1, valid=1, pc_out=1, fetch_count=1.
REQ-032 stall=1 for 3 cycles at pc_out=3 -> pc_out stays 3, if_id_* and fetch_count unchanged; fetch resumes at 3 on release.
REQ-033 branch_taken=1, target=16'd5, with stall=1 at the same edge -> pc_out=5, valid=0, fetch_count unchanged; the next edge delivers instruction 5.
REQ-034 instr_in=16'h0000 at pc_out=11 -> halted=1, pc_out held at 11, valid=0. A later branch_taken with target 16'd5 -> halted=0, pc_out=5.
REQ-035 PC preset to 16'hFFFF by branch, normal fetch -> pc_out=0, if_id_pc1=0.
REQ-036 rst asserted asynchronously mid-cycle during a stall -> all outputs take reset values before the next clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field widths, the
// end-of-program encoding and the fetch-stage state encoding.
package cpu_pkg;

  // Instruction field widths
  localparam int unsigned OpcodeW = 4;
  localparam int unsigned RegW    = 3;
  localparam int unsigned Imm6W   = 6;

  // Opcode encodings
  localparam logic [OpcodeW-1:0] OpAdd   = 4'b0001;
  localparam logic [OpcodeW-1:0] OpSub   = 4'b0010;
  localparam logic [OpcodeW-1:0] OpOr    = 4'b0100;
  localparam logic [OpcodeW-1:0] OpXor   = 4'b0101;
  localparam logic [OpcodeW-1:0] OpSl    = 4'b0110;
  localparam logic [OpcodeW-1:0] OpLoad  = 4'b1010;
  localparam logic [OpcodeW-1:0] OpStore = 4'b1011;
  localparam logic [OpcodeW-1:0] OpBz    = 4'b1100;

  // Unmapped instruction memory reads return this; fetch treats it as end-of-program.
  localparam logic [15:0] HaltInstrDefault = 16'h0000;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StHalted = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, RUN/HALTED
// control and a count of delivered instructions.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   pc_out            fetch address to instruction memory (registered)
//   instr_in          instruction memory data for pc_out
//   stall             hold PC and IF/ID
//   branch_taken      redirect to branch_target (overrides stall and halt)
//   branch_target     redirect address
//   if_id_instr       registered instruction to decode
//   if_id_pc1         registered pc+1 of that instruction
//   if_id_valid       IF/ID holds a real instruction
//   halted            fetch has stopped on the halt encoding
//   fetch_count       instructions delivered with valid=1 (wraps)
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'd0,
  parameter logic [15:0] HALT_INSTR = HaltInstrDefault
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] pc_out,
  input  logic [15:0] instr_in,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] if_id_instr,
  output logic        if_id_valid,
  output logic [15:0] if_id_pc1,
  output logic        halted,
  output logic [15:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  pc1_q, pc1_d;
  logic         valid_q, valid_d;
  logic [15:0]  count_q, count_d;
  logic [15:0]  pc_inc;

  assign pc_inc = pc_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    count_d = count_q;

    if (branch_taken) begin
      // Redirect flushes IF/ID; pc1 is left alone so bubbles keep the old value.
      pc_d    = branch_target;
      instr_d = '0;
      valid_d = 1'b0;
      state_d = StRun;
    end else if (state_q == StHalted) begin
      valid_d = 1'b0;
    end else if (stall) begin
      // Hold everything.
    end else if (instr_in == HALT_INSTR) begin
      valid_d = 1'b0;
      state_d = StHalted;
    end else begin
      instr_d = instr_in;
      pc1_d   = pc_inc;
      valid_d = 1'b1;
      pc_d    = pc_inc;
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign pc_out      = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == StHalted);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a small instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [15:0] pc_out;
  logic [15:0] instr_in;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] if_id_instr;
  logic        if_id_valid;
  logic [15:0] if_id_pc1;
  logic        halted;
  logic [15:0] fetch_count;

  int n_cmp;
  int n_err;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .pc_out       (pc_out),
    .instr_in     (instr_in),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .if_id_pc1    (if_id_pc1),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  // Memory image: 0 -> B683, 11 -> halt, 1..15 -> 1000+addr, FFFF -> 1234, else halt.
  function automatic logic [15:0] imem(input logic [15:0] a);
    if (a == 16'd0)           return 16'hB683;
    else if (a == 16'd11)     return 16'h0000;
    else if (a < 16'd16)      return 16'h1000 + a;
    else if (a == 16'hFFFF)   return 16'h1234;
    else                      return 16'h0000;
  endfunction

  assign instr_in = imem(pc_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                           input logic [15:0] pc1, input logic v, input logic h,
                           input logic [15:0] cnt);
    check_eq({tag, ".pc"},    pc_out,      pc);
    check_eq({tag, ".instr"}, if_id_instr, ins);
    check_eq({tag, ".pc1"},   if_id_pc1,   pc1);
    check_eq({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, v});
    check_eq({tag, ".halt"},  {15'd0, halted},      {15'd0, h});
    check_eq({tag, ".cnt"},   fetch_count, cnt);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 16'd0;

    #2;
    check_all("reset", 16'd0, 16'h0000, 16'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // First fetch after release
    tick();
    check_all("first", 16'd1, 16'hB683, 16'd1, 1'b1, 1'b0, 16'd1);
    tick();
    tick();
    check_all("run3", 16'd3, 16'h1002, 16'd3, 1'b1, 1'b0, 16'd3);

    // Stall three cycles at pc 3
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall", 16'd3, 16'h1002, 16'd3, 1'b1, 1'b0, 16'd3);
    end
    stall = 1'b0;
    tick();
    check_all("resume", 16'd4, 16'h1003, 16'd4, 1'b1, 1'b0, 16'd4);

    // Branch beats a simultaneous stall
    branch_taken = 1'b1;
    branch_target = 16'd5;
    stall = 1'b1;
    tick();
    check_all("branch", 16'd5, 16'h0000, 16'd4, 1'b0, 1'b0, 16'd4);
    branch_taken = 1'b0;
    stall = 1'b0;
    tick();
    check_all("tgt", 16'd6, 16'h1005, 16'd6, 1'b1, 1'b0, 16'd5);

    // Run to 11, then hit the halt encoding
    for (int i = 0; i < 5; i++) tick();
    check_all("pc11", 16'd11, 16'h100A, 16'd11, 1'b1, 1'b0, 16'd10);
    tick();
    check_all("halt", 16'd11, 16'h100A, 16'd11, 1'b0, 1'b1, 16'd10);
    stall = 1'b1;
    tick();
    check_all("halt_stall", 16'd11, 16'h100A, 16'd11, 1'b0, 1'b1, 16'd10);
    stall = 1'b0;

    // Branch out of HALTED
    branch_taken = 1'b1;
    branch_target = 16'd5;
    tick();
    check_all("unhalt", 16'd5, 16'h0000, 16'd11, 1'b0, 1'b0, 16'd10);

    // PC wrap from FFFF
    branch_target = 16'hFFFF;
    tick();
    check_eq("preset.pc", pc_out, 16'hFFFF);
    branch_taken = 1'b0;
    tick();
    check_all("wrap", 16'd0, 16'h1234, 16'd0, 1'b1, 1'b0, 16'd11);

    // Asynchronous reset mid-cycle during a stall
    stall = 1'b1;
    tick();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 16'd0, 16'h0000, 16'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    stall = 1'b0;
    rst = 1'b1;
    tick();
    check_all("refetch", 16'd1, 16'hB683, 16'd1, 1'b1, 1'b0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
